// File: rtl/sd_cmd_pkg.sv
// sd_cmd_phy shared types and constants.
// Optional build macro: SD_CMD_RESP_CRC_CHECK_EN.
package sd_cmd_pkg;

  localparam int FRAME_W = 48;
  localparam int CMD_W   = 40;
  localparam int CRC_W   = 7;

  localparam logic [CRC_W-1:0] CRC7_POLY = 7'h09;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    RESP_WAIT,
    RECV,
    DONE
  } state_t;

  function automatic logic [CRC_W-1:0] crc7_step(
    input logic [CRC_W-1:0] crc,
    input logic             b
  );
    logic fb;
    fb = b ^ crc[CRC_W-1];
    return {crc[CRC_W-2:0], 1'b0} ^ (fb ? CRC7_POLY : '0);
  endfunction

endpackage

// File: rtl/sd_cmd_phy_if.sv
// Controller-side handshake bundle for sd_cmd_phy.
// Optional build macro: SD_CMD_RESP_CRC_CHECK_EN.
interface sd_cmd_phy_if;
  import sd_cmd_pkg::*;

  logic             strobe_in;
  logic [CMD_W-1:0] cmd_in;
  logic             resp_en;
  logic             ack_out;
  logic             serial_ready;
  logic             strobe_out;
  logic [CMD_W-1:0] cmd_out;
  logic             ack_in;
  logic             timeout_err;
  logic             crc_err;

  modport master (
    output strobe_in, cmd_in, resp_en, ack_in,
    input  ack_out, serial_ready, strobe_out,
    input  cmd_out, timeout_err, crc_err
  );

  modport slave (
    input  strobe_in, cmd_in, resp_en, ack_in,
    output ack_out, serial_ready, strobe_out,
    output cmd_out, timeout_err, crc_err
  );

endinterface

// File: rtl/sd_crc7.sv
// Serial CRC7 (x^7+x^3+1), shared by transmit and receive paths.
// Optional build macro: SD_CMD_RESP_CRC_CHECK_EN.
module sd_crc7
  import sd_cmd_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic             bit_in,
  output logic [CRC_W-1:0] crc
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      crc <= '0;
    end else if (clear) begin
      crc <= '0;
    end else if (enable) begin
      crc <= crc7_step(crc, bit_in);
    end
  end

endmodule

// File: rtl/sd_cmd_phy.sv
// SD CMD line PHY: serialises commands with CRC7, captures responses.
// Optional build macro: SD_CMD_RESP_CRC_CHECK_EN (receive CRC check).
module sd_cmd_phy
  import sd_cmd_pkg::*;
#(
  parameter int RESP_TIMEOUT = 64,
  parameter int TO_W         = 7
) (
  input  logic         clock,
  input  logic         reset,
  sd_cmd_phy_if.slave  ctl,
  output logic         cmd_pin_out,
  output logic         cmd_pin_oe,
  input  logic         cmd_pin_in
);

  localparam logic [5:0] LAST = 6'(FRAME_W - 1);
  localparam logic [5:0] HDR  = 6'(CMD_W);

  state_t           state, state_n;
  logic [CMD_W-1:0] tx_sh;
  logic [CMD_W-1:0] rx_hdr;
  logic [5:0]       cnt;
  logic [TO_W-1:0]  to_cnt;
  logic             resp_r;
  logic             to_err;
  logic             to_hit;
  logic             crc_clr;
  logic             crc_en;
  logic             crc_bit;
  logic [CRC_W-1:0] crc;
  logic [2:0]       crc_idx;

  sd_crc7 u_crc (
    .clock  (clock),
    .reset  (reset),
    .clear  (crc_clr),
    .enable (crc_en),
    .bit_in (crc_bit),
    .crc    (crc)
  );

  assign to_hit = (to_cnt == TO_W'(RESP_TIMEOUT - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    crc_clr = 1'b0;
    crc_en  = 1'b0;
    crc_bit = tx_sh[CMD_W-1];
    unique case (state)
      IDLE: begin
        if (ctl.strobe_in) begin
          state_n = SEND;
          crc_clr = 1'b1;
        end
      end
      SEND: begin
        crc_en = (cnt < HDR);
        if (cnt == LAST) begin
          state_n = resp_r ? RESP_WAIT : DONE;
          crc_clr = 1'b1;
        end
      end
      RESP_WAIT: begin
        crc_bit = cmd_pin_in;
        // A start bit wins over a coincident timeout.
        if (!cmd_pin_in) begin
          state_n = RECV;
`ifdef SD_CMD_RESP_CRC_CHECK_EN
          crc_en  = 1'b1;
`endif
        end else if (to_hit) begin
          state_n = DONE;
        end
      end
      RECV: begin
        crc_bit = cmd_pin_in;
`ifdef SD_CMD_RESP_CRC_CHECK_EN
        crc_en  = (cnt < HDR);
`endif
        if (cnt == LAST) state_n = DONE;
      end
      DONE: begin
        if (ctl.ack_in) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

`ifdef SD_CMD_RESP_CRC_CHECK_EN
  logic [CRC_W-1:0] rx_crc;
  logic             crc_err_r;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_crc    <= '0;
      crc_err_r <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (ctl.strobe_in) crc_err_r <= 1'b0;
        end
        RECV: begin
          if (cnt == LAST)
            crc_err_r <= (crc != rx_crc);
          else if (cnt >= HDR)
            rx_crc <= {rx_crc[CRC_W-2:0], cmd_pin_in};
        end
        DONE: begin
          if (ctl.ack_in) crc_err_r <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign ctl.crc_err = crc_err_r;
`else
  assign ctl.crc_err = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tx_sh  <= '0;
      rx_hdr <= '0;
      cnt    <= '0;
      to_cnt <= '0;
      resp_r <= 1'b0;
      to_err <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (ctl.strobe_in) begin
            tx_sh  <= ctl.cmd_in;
            resp_r <= ctl.resp_en;
            rx_hdr <= '0;
            cnt    <= '0;
            to_err <= 1'b0;
          end
        end
        SEND: begin
          cnt   <= cnt + 6'd1;
          tx_sh <= {tx_sh[CMD_W-2:0], 1'b0};
          // Counts clocks since the end bit.
          if (cnt == LAST) to_cnt <= TO_W'(1);
        end
        RESP_WAIT: begin
          to_cnt <= to_cnt + TO_W'(1);
          if (!cmd_pin_in) begin
            rx_hdr <= {rx_hdr[CMD_W-2:0], 1'b0};
            cnt    <= 6'd1;
          end else if (to_hit) begin
            to_err <= 1'b1;
          end
        end
        RECV: begin
          cnt <= cnt + 6'd1;
          if (cnt < HDR)
            rx_hdr <= {rx_hdr[CMD_W-2:0], cmd_pin_in};
        end
        DONE: begin
          if (ctl.ack_in) to_err <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign crc_idx = 3'(6'd46 - cnt);

  always_comb begin
    cmd_pin_out = 1'b1;
    cmd_pin_oe  = 1'b0;
    if (state == SEND) begin
      cmd_pin_oe = 1'b1;
      if (cnt < HDR)       cmd_pin_out = tx_sh[CMD_W-1];
      else if (cnt < LAST) cmd_pin_out = crc[crc_idx];
    end
  end

  assign ctl.serial_ready = (state == IDLE);
  assign ctl.ack_out      = (state == SEND) && (cnt == LAST);
  assign ctl.strobe_out   = (state == DONE);
  assign ctl.timeout_err  = to_err;
  assign ctl.cmd_out      = (state == DONE) ? rx_hdr : '0;

endmodule

// File: tb/tb_sd_cmd_phy.sv
// Directed scoreboard bench for sd_cmd_phy.
// Honours SD_CMD_RESP_CRC_CHECK_EN for the expected crc_err.
module tb_sd_cmd_phy;
  import sd_cmd_pkg::*;

  localparam int RT = 64;

  typedef struct packed {
    logic [39:0] data;
    logic        to;
    logic        ce;
  } resp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic cmd_pin_out;
  logic cmd_pin_oe;
  logic cmd_pin_in;

  int total = 0;
  int bad   = 0;

  logic [47:0] frame_q[$];
  resp_t       resp_q[$];

  sd_cmd_phy_if ctl();

  sd_cmd_phy #(
    .RESP_TIMEOUT (RT),
    .TO_W         (7)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .ctl         (ctl.slave),
    .cmd_pin_out (cmd_pin_out),
    .cmd_pin_oe  (cmd_pin_oe),
    .cmd_pin_in  (cmd_pin_in)
  );

  always #5 clock = ~clock;

  function automatic logic [6:0] crc7(input logic [39:0] m);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = m[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'b000_1001;
    end
    return c;
  endfunction

  task automatic chk(input string tag,
                     input logic [47:0] obs,
                     input logic [47:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [39:0] cmd, input logic re);
    logic [47:0] got;
    logic [47:0] f;
    int          ackk;
    logic        oe_ok;
    logic        rdy0;
    got   = '0;
    ackk  = -1;
    oe_ok = 1'b1;
    ctl.cmd_in    = cmd;
    ctl.resp_en   = re;
    ctl.strobe_in = 1'b1;
    tick();
    ctl.strobe_in = 1'b0;
    rdy0 = ctl.serial_ready;
    for (int k = 0; k < 48; k++) begin
      got = {got[46:0], cmd_pin_out};
      if (ctl.ack_out && ackk < 0) ackk = k;
      if (!cmd_pin_oe) oe_ok = 1'b0;
      tick();
    end
    f = frame_q.pop_front();
    chk("frame", got, f);
    chk("ack_pos", 48'(ackk), 48'd47);
    chk("send_oe", 48'(oe_ok), 48'd1);
    chk("rdy_drop", 48'(rdy0), 48'd0);
  endtask

  task automatic drive_resp(input logic [47:0] r, input int gap);
    cmd_pin_in = 1'b1;
    for (int i = 0; i < gap; i++) tick();
    for (int i = 47; i >= 0; i--) begin
      cmd_pin_in = r[i];
      tick();
    end
    cmd_pin_in = 1'b1;
  endtask

  task automatic expect_done;
    resp_t r;
    r = resp_q.pop_front();
    chk("strobe_out", 48'(ctl.strobe_out), 48'd1);
    chk("cmd_out", 48'(ctl.cmd_out), 48'(r.data));
    chk("timeout_err", 48'(ctl.timeout_err), 48'(r.to));
    chk("crc_err", 48'(ctl.crc_err), 48'(r.ce));
    ctl.ack_in = 1'b1;
    tick();
    ctl.ack_in = 1'b0;
    chk("rel_ready", 48'(ctl.serial_ready), 48'd1);
    chk("rel_flags",
        48'({ctl.strobe_out, ctl.timeout_err, ctl.crc_err}),
        48'd0);
  endtask

  initial begin
    logic [47:0] rsp;
    logic [39:0] c;
    logic        ce_exp;
    int          n;

`ifdef SD_CMD_RESP_CRC_CHECK_EN
    ce_exp = 1'b1;
`else
    ce_exp = 1'b0;
`endif
    ctl.strobe_in = 1'b0;
    ctl.cmd_in    = '0;
    ctl.resp_en   = 1'b0;
    ctl.ack_in    = 1'b0;
    cmd_pin_in    = 1'b1;

    tick();
    chk("rst_ready", 48'(ctl.serial_ready), 48'd1);
    chk("rst_pin", 48'(cmd_pin_out), 48'd1);
    chk("rst_zero",
        48'({cmd_pin_oe, ctl.ack_out, ctl.strobe_out,
             ctl.timeout_err, ctl.crc_err}), 48'd0);
    chk("rst_cmd_out", 48'(ctl.cmd_out), 48'd0);
    reset = 1'b1;
    tick();

    // CMD0
    frame_q.push_back(48'h40_0000_0000_95);
    resp_q.push_back('{40'h0, 1'b0, 1'b0});
    send(40'h40_0000_0000, 1'b0);
    expect_done();

    // CMD17 arg 0
    frame_q.push_back(48'h51_0000_0000_55);
    resp_q.push_back('{40'h0, 1'b0, 1'b0});
    send(40'h51_0000_0000, 1'b0);
    expect_done();

    // CMD8 with clean response
    frame_q.push_back(48'h48_0000_01AA_87);
    resp_q.push_back('{40'h08_0000_01AA, 1'b0, 1'b0});
    send(40'h48_0000_01AA, 1'b1);
    chk("wait_oe", 48'(cmd_pin_oe), 48'd0);
    drive_resp(48'h08_0000_01AA_13, 3);
    expect_done();

    // CMD8 with one argument bit corrupted
    rsp = 48'h08_0000_01AA_13 ^ 48'h200;
    frame_q.push_back(48'h48_0000_01AA_87);
    resp_q.push_back('{rsp[47:8], 1'b0, ce_exp});
    send(40'h48_0000_01AA, 1'b1);
    drive_resp(rsp, 0);
    expect_done();

    // Timeout with CMD line held high
    c = 40'h77_0000_0000;
    frame_q.push_back({c, crc7(c), 1'b1});
    resp_q.push_back('{40'h0, 1'b1, 1'b0});
    send(c, 1'b1);
    n = 1;
    while (!ctl.strobe_out && n < 200) begin
      tick();
      n++;
    end
    chk("to_latency", 48'(n), 48'(RT));
    expect_done();

    frame_q.push_back(48'h40_0000_0000_95);
    resp_q.push_back('{40'h0, 1'b0, 1'b0});
    send(40'h40_0000_0000, 1'b0);
    expect_done();

    // Random commands checked against the CRC model
    for (int i = 0; i < 2; i++) begin
      c = {2'b01, 6'($urandom), 32'($urandom)};
      frame_q.push_back({c, crc7(c), 1'b1});
      resp_q.push_back('{40'h0, 1'b0, 1'b0});
      send(c, 1'b0);
      expect_done();
    end

    // Reset at bit 20 of SEND
    ctl.cmd_in    = 40'h40_0000_0000;
    ctl.resp_en   = 1'b0;
    ctl.strobe_in = 1'b1;
    tick();
    ctl.strobe_in = 1'b0;
    for (int k = 0; k < 20; k++) tick();
    chk("pre_rst_oe", 48'(cmd_pin_oe), 48'd1);
    reset = 1'b0;
    #1;
    chk("mid_rst_oe", 48'(cmd_pin_oe), 48'd0);
    chk("mid_rst_pin", 48'(cmd_pin_out), 48'd1);
    chk("mid_rst_rdy", 48'(ctl.serial_ready), 48'd1);
    tick();
    reset = 1'b1;
    tick();
    tick();
    chk("post_rst",
        48'({cmd_pin_oe, ctl.strobe_out, ctl.serial_ready}),
        48'd1);

    // strobe_in during DONE is ignored
    frame_q.push_back(48'h51_0000_0000_55);
    resp_q.push_back('{40'h0, 1'b0, 1'b0});
    send(40'h51_0000_0000, 1'b0);
    ctl.cmd_in    = 40'h40_0000_0000;
    ctl.strobe_in = 1'b1;
    tick();
    ctl.strobe_in = 1'b0;
    tick();
    chk("done_hold",
        48'({ctl.strobe_out, ctl.serial_ready, cmd_pin_oe}),
        48'b100);
    expect_done();
    tick();
    chk("no_late_send",
        48'({cmd_pin_oe, ctl.serial_ready}), 48'b01);

    chk("q_empty", 48'(frame_q.size() + resp_q.size()), 48'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sd_cmd_phy.md
Name: sd_cmd_phy

Overview:
Serial command physical layer, directly downstream of the command controller.
- Accepts a 40-bit command (start bit, transmission bit, index, argument) via strobe handshake.
- Appends CRC7 and the end bit, then shifts the 48-bit frame onto the SD CMD line MSB first, one bit per clock.
- Optionally captures a 48-bit response and returns its 40-bit header/argument to the controller, with CRC and timeout status.

Parameters:
RESP_TIMEOUT, 64, clocks to wait for a response start bit after the end bit before flagging timeout (NCR window).
TO_W, 7, width of the timeout counter; must hold RESP_TIMEOUT.

Ports:
clock  in  1  single clock; all state on posedge.
reset  in  1  asynchronous, active-low reset.
strobe_in  in  1  command valid from controller; sampled only when serial_ready=1.
cmd_in  in  40  command frame bits [47:8]; [39:38] must be 2'b01.
resp_en  in  1  sampled with strobe_in; 1 = response expected.
ack_out  out  1  one-cycle pulse when the end bit of the command is driven.
serial_ready  out  1  high only in IDLE.
strobe_out  out  1  response/status valid; held until ack_in.
cmd_out  out  40  received response bits [47:8]; 0 when there is no response or on timeout.
ack_in  in  1  controller consumed the response; releases DONE.
timeout_err  out  1  valid with strobe_out.
crc_err  out  1  valid with strobe_out.
cmd_pin_out  out  1  CMD line drive value; idles at 1.
cmd_pin_oe  out  1  CMD line output enable.
cmd_pin_in  in  1  CMD line sampled value.

Behaviour:
- Reset (reset=0, async): state IDLE.
  - Outputs: serial_ready=1, cmd_pin_out=1, every other output 0.
  - Shift, CRC and counters cleared.
  - Reset mid-frame aborts immediately; no partial frame resumes.
- IDLE: serial_ready=1.
  - strobe_in=1 latches {cmd_in, resp_en}, clears the CRC, and enters SEND.
  - serial_ready drops in the next cycle.
- SEND, 48 cycles: cmd_pin_oe=1.
  - Cycle k (k=0..47) drives frame bit 47-k, starting the cycle after strobe_in.
  - Bits 47..8 come from cmd_in. CRC7 (poly x^7+x^3+1, init 0) updates serially over these 40 bits.
  - Bits 7..1 are the CRC MSB first; bit 0 is 1.
  - ack_out=1 exactly in the cycle bit 0 is driven.
  - Next state: RESP_WAIT if resp_en, otherwise DONE.
- RESP_WAIT: cmd_pin_oe=0 and the timeout counter counts up.
  - cmd_pin_in=0 (start bit) goes to RECV and captures that bit as bit 47.
  - If the counter reaches RESP_TIMEOUT with no start bit, go to DONE with timeout_err=1 and cmd_out=0.
  - A start bit in the same cycle as the counter reaching RESP_TIMEOUT is accepted; timeout loses.
- RECV: 47 further bits shift in MSB first.
  - CRC7 is computed over bits 47..8 and compared with bits 7..1.
  - The end bit is not checked.
  - Then go to DONE.
- DONE: strobe_out=1, with cmd_out, timeout_err and crc_err stable.
  - ack_in=1 returns to IDLE next cycle, with strobe_out=0 and the error flags cleared.
  - strobe_in is ignored in DONE because serial_ready=0.
- Latency, no response: ack_out at cycle 48 after strobe_in; strobe_out at cycle 49.
- cmd_in[39:38] is not checked; it is transmitted as given.

Optional Feature:
SD_CMD_RESP_CRC_CHECK_EN
- Defined: response CRC is checked and crc_err is asserted on mismatch.
- Undefined: no receive CRC logic; crc_err tied 0. The transmit CRC is always present.

Decomposition:
- Package sd_cmd_pkg holds:
  - state encodings IDLE, SEND, RESP_WAIT, RECV, DONE;
  - FRAME_W=48, CMD_W=40, CRC_W=7;
  - CRC7 polynomial constant 7'h09.
- Sub-module sd_crc7: serial CRC7 with clear, enable, bit-in and 7-bit crc out. It is instantiated once and reused for transmit and receive, cleared on entry to SEND and RESP_WAIT.

Test Plan:
- CMD0: cmd_in={2'b01,6'd0,32'h0}, resp_en=0 -> pin frame 48'h40_0000_0000_95; ack_out at cycle 48; strobe_out at cycle 49 with cmd_out=0 and both errors 0.
- CMD17 arg 0: resp_en=0 -> frame 48'h51_0000_0000_55.
- CMD8 arg 32'h1AA, resp_en=1; bench drives response 48'h08_0000_01AA_13 -> cmd_out=40'h08_0000_01AA, crc_err=0, timeout_err=0.
- Same as the CMD8 case but the bench flips one argument bit -> crc_err=1 when the macro is defined, 0 when undefined.
- resp_en=1, CMD line held high -> timeout_err=1 exactly RESP_TIMEOUT cycles after the end bit; cmd_out=0; after ack_in, serial_ready=1 and a second strobe_in is accepted.
- Reset asserted at bit 20 of SEND -> same cycle: cmd_pin_oe=0, cmd_pin_out=1, serial_ready=1; strobe_in pulsed during DONE without ack_in -> no effect.
